// File: rtl/demo_step_ctrl_if.sv
// Board-side bundle for the demo run controller: raw board inputs in,
// debounced switches, enable pulse, mode and enable count out.
interface demo_step_ctrl_if #(
    parameter int SW_W  = 10,
    parameter int CNT_W = 16
);
    logic [SW_W-1:0]  sw_raw;
    logic [1:0]       mode_raw;
    logic             step_raw;
    logic [SW_W-1:0]  sw_db;
    logic             cpu_en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] enable_count;

    modport master (
        output sw_raw, mode_raw, step_raw,
        input  sw_db, cpu_en, mode, enable_count
    );

    modport slave (
        input  sw_raw, mode_raw, step_raw,
        output sw_db, cpu_en, mode, enable_count
    );
endinterface

// File: rtl/demo_step_ctrl.sv
// Demo run controller: synchronises and debounces board inputs, then issues
// single-cycle cpu clock-enables in halt / run / step / fast modes.
module demo_step_ctrl #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 10,
    parameter int SW_W       = 10,
    parameter int DEB_CYCLES = 50_000,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    demo_step_ctrl_if.slave   bus
);
    localparam int DIV    = CLK_HZ / TICK_HZ;
    localparam int NB     = SW_W + 3;
    localparam int DCW    = $clog2(DEB_CYCLES + 1);
    localparam int PW     = $clog2(DIV);
    localparam int SETTLE = DEB_CYCLES + 2;
    localparam int STW    = $clog2(SETTLE + 1);

    localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);
    localparam logic [STW-1:0] SETTLE_END = STW'(SETTLE);

    localparam logic [1:0] ST_HALT = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_STEP = 2'b10;
    localparam logic [1:0] ST_FAST = 2'b11;

    logic [NB-1:0]    w_raw;
    logic [NB-1:0]    r_s1, r_s2;
    logic [NB-1:0]    w_db;
    logic [1:0]       w_mode;
    logic             w_step_db;
    logic [1:0]       r_mode_d1;
    logic             w_chg;
    logic [PW-1:0]    r_presc;
    logic             w_tick;
    logic [STW-1:0]   r_settle;
    logic             r_armed;
    logic             r_step_d1;
    logic             w_step_evt;
    logic             r_cpu_en;
    logic [CNT_W-1:0] r_count;

    assign w_raw = {bus.step_raw, bus.mode_raw, bus.sw_raw};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    // Per-bit debounce: db only follows sync after DEB_CYCLES straight disagreeing cycles.
    for (genvar g = 0; g < NB; g++) begin : g_deb
        logic [DCW-1:0] r_cnt;
        logic           r_bit;
        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
                r_bit <= 1'b0;
            end else if (r_s2[g] == r_bit) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_bit <= r_s2[g];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign w_db[g] = r_bit;
    end

    assign w_mode    = w_db[SW_W +: 2];
    assign w_step_db = w_db[SW_W + 2];
    assign w_chg     = (w_mode != r_mode_d1);
    assign w_tick    = (r_presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset || w_chg || w_tick) r_presc <= '0;
        else                          r_presc <= r_presc + 1'b1;
    end

    // Arming waits until a button held through reset has had time to debounce high,
    // so only a genuine release can arm the step edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle  <= '0;
            r_armed   <= 1'b0;
            r_step_d1 <= 1'b0;
            r_mode_d1 <= ST_HALT;
        end else begin
            if (r_settle != SETTLE_END) r_settle <= r_settle + 1'b1;
            if (r_settle == SETTLE_END && !w_step_db) r_armed <= 1'b1;
            r_step_d1 <= w_step_db;
            r_mode_d1 <= w_mode;
        end
    end

    assign w_step_evt = w_step_db & ~r_step_d1 & r_armed;

    always_ff @(posedge clk) begin
        if (reset || w_chg) begin
            r_cpu_en <= 1'b0;
        end else begin
            case (w_mode)
                ST_HALT: r_cpu_en <= 1'b0;
                ST_RUN:  r_cpu_en <= w_tick;
                ST_STEP: r_cpu_en <= w_step_evt;
                ST_FAST: r_cpu_en <= 1'b1;
                default: r_cpu_en <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                          r_count <= '0;
        else if (r_cpu_en && r_count != '1) r_count <= r_count + 1'b1;
    end

    assign bus.sw_db        = w_db[SW_W-1:0];
    assign bus.mode         = w_mode;
    assign bus.cpu_en       = r_cpu_en;
    assign bus.enable_count = r_count;
endmodule

// File: tb/tb_demo_step_ctrl.sv
// Bench for demo_step_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of the controller's rules.
module tb_demo_step_ctrl;
    localparam int SW_W = 10;
    localparam int CNT_W = 4;
    localparam int DEB = 3;
    localparam int DIV = 4;
    localparam int NB = SW_W + 3;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    demo_step_ctrl_if #(.SW_W(SW_W), .CNT_W(CNT_W)) bus ();

    demo_step_ctrl #(
        .CLK_HZ(40), .TICK_HZ(10), .SW_W(SW_W), .DEB_CYCLES(DEB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state
    logic [NB-1:0] m_s1, m_s2, m_db;
    int            m_run [NB];
    int            m_age;
    logic          m_armed, m_rel, m_stepprev, m_en;
    int            m_cnt;

    task automatic model_update();
        logic [NB-1:0] raw, ndb;
        logic          evt, nen;
        int            ncnt;
        raw = {bus.step_raw, bus.mode_raw, bus.sw_raw};
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0;
            for (int i = 0; i < NB; i++) m_run[i] = 0;
            m_age = 1; m_armed = 0; m_rel = 0; m_stepprev = 0; m_en = 0; m_cnt = 0;
        end else begin
            evt  = m_db[NB-1] && !m_stepprev && m_armed;
            ncnt = (m_en && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
            if (m_age == 0) nen = 0;
            else case (m_db[SW_W +: 2])
                2'd1:    nen = (m_age % DIV == 0);
                2'd2:    nen = evt;
                2'd3:    nen = 1;
                default: nen = 0;
            endcase
            m_armed = m_armed || (m_rel && !m_db[NB-1]);
            m_rel   = m_rel || !raw[NB-1];
            ndb = m_db;
            for (int i = 0; i < NB; i++) begin
                if (m_s2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        ndb[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else m_run[i] = 0;
            end
            m_age = (ndb[SW_W +: 2] != m_db[SW_W +: 2]) ? 0 : m_age + 1;
            m_stepprev = m_db[NB-1];
            m_db = ndb;
            m_s2 = m_s1;
            m_s1 = raw;
            m_en = nen;
            m_cnt = ncnt;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("cpu_en", 32'(bus.cpu_en), 32'(m_en));
        chk("mode", 32'(bus.mode), 32'(m_db[SW_W +: 2]));
        chk("sw_db", 32'(bus.sw_db), 32'(m_db[SW_W-1:0]));
        chk("enable_count", 32'(bus.enable_count), 32'(m_cnt));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic run_count(input int n, output int pulses, output int first);
        pulses = 0;
        first  = 0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (bus.cpu_en === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
    endtask

    int p, f;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.sw_raw = '0;
        bus.mode_raw = 2'b00;
        bus.step_raw = 1'b0;
        ticks(3);
        chk("rst_count", 32'(bus.enable_count), 0);
        chk("rst_mode", 32'(bus.mode), 0);
        rst = 1'b0;
        ticks(10);

        // clean switch change lands exactly DEB+2 cycles later
        bus.sw_raw = 10'h2A5;
        ticks(4);
        chk("sw_early", 32'(bus.sw_db), 0);
        tick();
        chk("sw_lat5", 32'(bus.sw_db), 'h2A5);
        ticks(4);
        bus.sw_raw = 10'h3FF;
        ticks(2);
        bus.sw_raw = 10'h2A5;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("sw_glitch", 32'(bus.sw_db), 'h2A5);
        end

        // RUN: one pulse per DIV cycles
        bus.mode_raw = 2'b01;
        ticks(5);
        chk("run_mode", 32'(bus.mode), 1);
        tick();
        run_count(16, p, f);
        chk("run_pulses", p, 4);
        chk("run_first", f, 4);
        ticks(3);

        // STEP: one pulse per press, 6 cycles after it
        bus.mode_raw = 2'b10;
        ticks(8);
        bus.step_raw = 1'b1;
        run_count(20, p, f);
        chk("step_pulses", p, 1);
        chk("step_lat", f, 6);
        bus.step_raw = 1'b0;
        ticks(8);
        bus.step_raw = 1'b1;
        run_count(12, p, f);
        chk("step2_pulses", p, 1);
        bus.step_raw = 1'b0;
        ticks(8);

        // button held through reset never steps until released
        bus.step_raw = 1'b1;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        run_count(20, p, f);
        chk("held_pulses", p, 0);
        bus.step_raw = 1'b0;
        ticks(8);
        bus.step_raw = 1'b1;
        run_count(12, p, f);
        chk("rel_pulses", p, 1);
        bus.step_raw = 1'b0;
        ticks(8);

        // FAST saturates the counter; reset clears at once
        bus.mode_raw = 2'b11;
        ticks(25);
        chk("fast_sat", 32'(bus.enable_count), CMAX);
        chk("fast_en", 32'(bus.cpu_en), 1);
        rst = 1'b1;
        tick();
        chk("midrst_en", 32'(bus.cpu_en), 0);
        chk("midrst_cnt", 32'(bus.enable_count), 0);
        rst = 1'b0;
        bus.mode_raw = 2'b00;
        ticks(8);

        // RUN -> HALT: nothing after the mode update
        bus.mode_raw = 2'b01;
        ticks(20);
        bus.mode_raw = 2'b00;
        ticks(5);
        chk("halt_mode", 32'(bus.mode), 0);
        run_count(10, p, f);
        chk("halt_pulses", p, 0);

        // step pressed in RUN is not remembered into STEP
        bus.mode_raw = 2'b01;
        ticks(8);
        bus.step_raw = 1'b1;
        ticks(10);
        bus.step_raw = 1'b0;
        ticks(8);
        bus.mode_raw = 2'b10;
        ticks(5);
        run_count(12, p, f);
        chk("nq_pulses", p, 0);

        // random stimulus against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) == 0) bus.sw_raw = 10'($urandom);
            if ($urandom_range(0, 29) == 0) bus.mode_raw = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) bus.step_raw = ~bus.step_raw;
            if ($urandom_range(0, 199) == 0) begin
                bus.step_raw = 1'b0;
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
